serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_fa_bit.sv | 16 +
 rtl/serial_adder.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_fa_bit.sv
// One-bit full-adder slice; the only arithmetic in the serial adder.
module serial_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s,
    output logic c_o
);

    // Sum and carry of a single bit position.
    always_comb begin
        s   = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
    end

endmodule : serial_fa_bit

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted out LSB-first through one
// full-adder slice, with the carry held in a flop between bit positions. The
// parallel sum and carry-out are registered when the last bit is produced.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sa_state_t        state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] sum_sr_q;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] sum_sr_d;

    serial_fa_bit u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s   (bit_s),
        .c_o (bit_c)
    );

    // Next sum shift-register value: shift right, new sum bit enters at the MSB.
    // Written as shift-then-overwrite so it stays legal for WIDTH == 1.
    always_comb begin
        sum_sr_d            = sum_sr_q >> 1;
        sum_sr_d[WIDTH-1]   = bit_s;
    end

    // Control FSM together with the datapath registers it sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        carry_q  <= cin;
                        cnt_q    <= '0;
                        sum_sr_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    sum_sr_q <= sum_sr_d;
                    carry_q  <= bit_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Last bit: publish the full sum including this cycle's bit.
                        sum_q   <= sum_sr_d;
                        cout_q  <= bit_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder
